// File: rtl/decompress_fetcher_pkg.sv
// Shared definitions for the decompression path: fetcher FSM encoding and bus width defaults.
// Also imported by the DMA and decompress_handler blocks.
package decompress_fetcher_pkg;

    localparam int unsigned AddrWDefault = 16;
    localparam int unsigned IdxWDefault  = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRd1,
        StRd2,
        StDispatch,
        StWaitDec,
        StAdvance,
        StFinish
    } fetchState_e;

endpackage

// File: rtl/decompress_fetcher.sv
// Feeds a compressed byte stream from RAM to the decompressor as (current, next) byte pairs,
// advancing to whatever stream position the decompressor hands back after each step.
module decompress_fetcher
    import decompress_fetcher_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned IDX_W  = IdxWDefault
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [IDX_W-1:0]  length,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    input  logic [7:0]        ram_data,
    input  logic              ram_done_read,
    output logic [7:0]        in1,
    output logic [7:0]        in2,
    output logic [IDX_W-1:0]  byte_indx,
    output logic [2:0]        bit_indx,
    output logic              work,
    input  logic              dec_done,
    input  logic [IDX_W-1:0]  new_byte_indx,
    input  logic [2:0]        new_bit_indx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    fetchState_e       state;
    logic [ADDR_W-1:0] baseAddr;
    logic [IDX_W-1:0]  lenReg;
    logic [IDX_W-1:0]  newByte;
    logic [2:0]        newBit;

    logic [IDX_W:0]    nextIdx;
    logic [ADDR_W-1:0] rdAddr1;
    logic [ADDR_W-1:0] rdAddr2;
    logic              nextPastEnd;
    logic              newPastEnd;
    logic              newBehind;
    logic              newSame;
    logic              newNext;

    // Extra index bit keeps byte_indx+1 from wrapping when compared against length.
    assign nextIdx     = {1'b0, byte_indx} + {{IDX_W{1'b0}}, 1'b1};
    assign rdAddr1     = baseAddr + ADDR_W'(byte_indx);
    assign rdAddr2     = rdAddr1 + ADDR_W'(1);
    assign nextPastEnd = nextIdx >= {1'b0, lenReg};
    assign newPastEnd  = newByte >= lenReg;
    assign newBehind   = (newByte < byte_indx) || ((newByte == byte_indx) && (newBit < bit_indx));
    assign newSame     = newByte == byte_indx;
    assign newNext     = {1'b0, newByte} == nextIdx;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state       <= StIdle;
            baseAddr    <= '0;
            lenReg      <= '0;
            newByte     <= '0;
            newBit      <= '0;
            ram_address <= '0;
            ram_read    <= 1'b0;
            in1         <= '0;
            in2         <= '0;
            byte_indx   <= '0;
            bit_indx    <= '0;
            work        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            work <= 1'b0;
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        baseAddr  <= base_addr;
                        lenReg    <= length;
                        byte_indx <= '0;
                        bit_indx  <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (length == '0) ? StFinish : StRd1;
                    end
                end
                // A read is issued on the first cycle in the state and held until completion.
                StRd1: begin
                    if (!ram_read) begin
                        ram_read    <= 1'b1;
                        ram_address <= rdAddr1;
                    end else if (ram_done_read) begin
                        ram_read <= 1'b0;
                        in1      <= ram_data;
                        state    <= StRd2;
                    end
                end
                StRd2: begin
                    if (!ram_read) begin
                        if (nextPastEnd) begin
                            in2   <= '0;
                            state <= StDispatch;
                        end else begin
                            ram_read    <= 1'b1;
                            ram_address <= rdAddr2;
                        end
                    end else if (ram_done_read) begin
                        ram_read <= 1'b0;
                        in2      <= ram_data;
                        state    <= StDispatch;
                    end
                end
                StDispatch: begin
                    work  <= 1'b1;
                    state <= StWaitDec;
                end
                StWaitDec: begin
                    if (dec_done) begin
                        newByte <= new_byte_indx;
                        newBit  <= new_bit_indx;
                        state   <= StAdvance;
                    end
                end
                StAdvance: begin
                    if (newPastEnd) begin
                        byte_indx <= newByte;
                        bit_indx  <= newBit;
                        state     <= StFinish;
                    end else if (newBehind) begin
                        err   <= 1'b1;
                        state <= StFinish;
                    end else begin
                        byte_indx <= newByte;
                        bit_indx  <= newBit;
                        if (newSame) begin
                            state <= StDispatch;
                        end else if (newNext) begin
                            in1   <= in2;
                            state <= StRd2;
                        end else begin
                            state <= StRd1;
                        end
                    end
                end
                StFinish: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_decompress_fetcher.sv
// Bench for decompress_fetcher: DMA and decompressor models with expected reads and work
// snapshots queued up front and consumed as the DUT issues them.
module tb_decompress_fetcher;
    import decompress_fetcher_pkg::*;

    localparam int unsigned AW = AddrWDefault;
    localparam int unsigned IW = IdxWDefault;

    typedef struct packed {
        logic [7:0]    in1;
        logic [7:0]    in2;
        logic [IW-1:0] bytePos;
        logic [2:0]    bitPos;
    } workSnap_t;

    typedef struct packed {
        logic [IW-1:0] bytePos;
        logic [2:0]    bitPos;
    } pos_t;

    logic          clk = 1'b0;
    logic          RST;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [IW-1:0] length;
    logic [AW-1:0] ram_address;
    logic          ram_read;
    logic [7:0]    ram_data;
    logic          ram_done_read;
    logic [7:0]    in1;
    logic [7:0]    in2;
    logic [IW-1:0] byte_indx;
    logic [2:0]    bit_indx;
    logic          work;
    logic          dec_done;
    logic [IW-1:0] new_byte_indx;
    logic [2:0]    new_bit_indx;
    logic          busy;
    logic          done;
    logic          err;

    logic [7:0]    mem [0:65535];
    logic [AW-1:0] expReads [$];
    workSnap_t     expWorks [$];
    pos_t          decScript [$];

    logic          dmaHold;
    logic          lateDoneReq;
    int            checkCount = 0;
    int            passCount  = 0;

    decompress_fetcher #(
        .ADDR_W(AW),
        .IDX_W (IW)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .ram_address  (ram_address),
        .ram_read     (ram_read),
        .ram_data     (ram_data),
        .ram_done_read(ram_done_read),
        .in1          (in1),
        .in2          (in2),
        .byte_indx    (byte_indx),
        .bit_indx     (bit_indx),
        .work         (work),
        .dec_done     (dec_done),
        .new_byte_indx(new_byte_indx),
        .new_bit_indx (new_bit_indx),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial forever #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // DMA and decompressor models; all sampling happens on the falling edge.
    initial begin
        logic          dmaBusy;
        int            dmaWait;
        logic [AW-1:0] dmaAddr;
        int            decWait;
        workSnap_t     ws;
        pos_t          p;
        dmaBusy = 1'b0; dmaWait = 0; dmaAddr = '0; decWait = 0;
        ram_done_read = 1'b0; ram_data = '0;
        dec_done = 1'b0; new_byte_indx = '0; new_bit_indx = '0;
        forever begin
            @(negedge clk);
            ram_done_read = 1'b0;
            dec_done      = 1'b0;
            if (RST) begin
                dmaBusy = 1'b0;
                dmaWait = 0;
                decWait = 0;
            end else begin
                if (lateDoneReq) begin
                    ram_done_read = 1'b1;
                    ram_data      = 8'hEE;
                end
                if (!dmaHold) begin
                    if (dmaBusy && !ram_read) dmaBusy = 1'b0;
                    if (ram_read && !dmaBusy) begin
                        dmaBusy = 1'b1;
                        dmaAddr = ram_address;
                        dmaWait = 1;
                        checkVal("readExpected", 64'(expReads.size() > 0), 64'd1);
                        if (expReads.size() > 0)
                            checkVal("readAddr", 64'(ram_address), 64'(expReads.pop_front()));
                    end else if (dmaBusy && ram_read) begin
                        checkVal("addrHold", 64'(ram_address), 64'(dmaAddr));
                        if (dmaWait > 0) begin
                            dmaWait--;
                        end else begin
                            ram_done_read = 1'b1;
                            ram_data      = mem[dmaAddr];
                        end
                    end
                end
                if (work) begin
                    checkVal("workNoRead", 64'(ram_read), 64'd0);
                    checkVal("workExpected", 64'(expWorks.size() > 0), 64'd1);
                    if (expWorks.size() > 0) begin
                        ws = expWorks.pop_front();
                        checkVal("workIn1", 64'(in1), 64'(ws.in1));
                        checkVal("workIn2", 64'(in2), 64'(ws.in2));
                        checkVal("workByte", 64'(byte_indx), 64'(ws.bytePos));
                        checkVal("workBit", 64'(bit_indx), 64'(ws.bitPos));
                    end
                    decWait = 2;
                end else if (decWait > 0) begin
                    decWait--;
                    if (decWait == 0) begin
                        checkVal("decScript", 64'(decScript.size() > 0), 64'd1);
                        if (decScript.size() > 0) begin
                            p             = decScript.pop_front();
                            dec_done      = 1'b1;
                            new_byte_indx = p.bytePos;
                            new_bit_indx  = p.bitPos;
                        end
                    end
                end
            end
        end
    end

    task automatic pushWork(input int unsigned a1, input int unsigned a2, input logic [IW-1:0] b,
                            input logic [2:0] t);
        workSnap_t ws;
        ws.in1 = mem[a1[15:0]];
        ws.in2 = mem[a2[15:0]];
        ws.bytePos = b;
        ws.bitPos  = t;
        expWorks.push_back(ws);
    endtask

    task automatic pushRet(input logic [IW-1:0] b, input logic [2:0] t);
        pos_t p;
        p.bytePos = b;
        p.bitPos  = t;
        decScript.push_back(p);
    endtask

    task automatic runStream(input logic [AW-1:0] b, input logic [IW-1:0] len, output int cycles);
        @(negedge clk);
        base_addr = b;
        length    = len;
        start     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        checkVal("busyAfterStart", 64'(busy), 64'd1);
        checkVal("errClearedOnStart", 64'(err), 64'd0);
        while (!done && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        checkVal("doneSeen", 64'(done), 64'd1);
        @(negedge clk);
        checkVal("donePulseOnce", 64'(done), 64'd0);
        checkVal("busyDropped", 64'(busy), 64'd0);
        checkVal("readsLeft", 64'(expReads.size()), 64'd0);
        checkVal("worksLeft", 64'(expWorks.size()), 64'd0);
        checkVal("decLeft", 64'(decScript.size()), 64'd0);
    endtask

    task automatic checkAllClear(input string tag);
        checkVal({tag, "Ctrl"}, 64'({ram_read, work, busy, done, err}), 64'd0);
        checkVal({tag, "Bytes"}, 64'({in1, in2}), 64'd0);
        checkVal({tag, "Addr"}, 64'(ram_address), 64'd0);
        checkVal({tag, "Pos"}, 64'({byte_indx, bit_indx}), 64'd0);
    endtask

    initial begin
        int cycles;
        int cnt;
        RST = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        dmaHold = 1'b0; lateDoneReq = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[16'h0100] = 8'hAA; mem[16'h0101] = 8'hBB;
        mem[16'h0102] = 8'hCC; mem[16'h0103] = 8'hDD;
        repeat (3) @(negedge clk);
        checkAllClear("reset");
        RST = 1'b0;

        // Basic four-byte stream with a mix of partial and whole-byte advances
        expReads = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
        pushWork(32'h100, 32'h101, 0, 0);
        pushWork(32'h101, 32'h102, 1, 3);
        pushWork(32'h102, 32'h103, 2, 0);
        pushRet(1, 3); pushRet(2, 0); pushRet(4, 0);
        runStream(16'h0100, 4, cycles);

        // Single byte: next byte is past the end and reads as zero
        expReads = '{16'h0300};
        begin
            workSnap_t ws;
            ws.in1 = mem[16'h0300]; ws.in2 = 8'h00; ws.bytePos = 0; ws.bitPos = 0;
            expWorks.push_back(ws);
        end
        pushRet(1, 0);
        runStream(16'h0300, 1, cycles);

        // Same-byte advance re-dispatches without touching RAM
        expReads = '{16'h0200, 16'h0201};
        pushWork(32'h200, 32'h201, 0, 0);
        pushWork(32'h200, 32'h201, 0, 5);
        pushRet(0, 5); pushRet(4, 0);
        runStream(16'h0200, 4, cycles);

        // Address wraps around the top of RAM
        expReads = '{16'hFFFF, 16'h0000};
        pushWork(32'hFFFF, 32'h0, 0, 0);
        pushRet(2, 0);
        runStream(16'hFFFF, 2, cycles);

        // Backwards position sets the sticky error
        expReads = '{16'h0400, 16'h0401, 16'h0402, 16'h0403};
        pushWork(32'h400, 32'h401, 0, 0);
        pushWork(32'h402, 32'h403, 2, 0);
        pushRet(2, 0); pushRet(1, 0);
        runStream(16'h0400, 8, cycles);
        checkVal("errSticky", 64'(err), 64'd1);
        @(negedge clk);
        checkVal("errStillSet", 64'(err), 64'd1);

        // Empty stream: done two cycles after start, and err cleared by the start
        runStream(16'h0500, 0, cycles);
        checkVal("emptyLatency", 64'(cycles), 64'd2);

        // Reset in the middle of a read, then a stale DMA completion
        @(posedge clk);
        dmaHold = 1'b1;
        @(negedge clk);
        base_addr = 16'h0100; length = 4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!ram_read && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkVal("readBeforeReset", 64'(ram_read), 64'd1);
        #2 RST = 1'b1;
        #1 checkAllClear("midReadReset");
        @(posedge clk);
        #1 RST = 1'b0;
        lateDoneReq = 1'b1;
        @(posedge clk);
        #1 lateDoneReq = 1'b0;
        repeat (3) @(negedge clk);
        checkAllClear("afterLateDone");
        @(posedge clk);
        dmaHold = 1'b0;
        runStream(16'h0600, 0, cycles);
        checkVal("idleAfterReset", 64'(cycles), 64'd2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
